// File: rtl/pulse_scheduler_if.sv
// Request/grant bundle between a set of delayed-strobe requesters and the
// shared pulse scheduler. The master side is the requester pool. The slave
// side is the scheduler itself.
interface pulse_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 8
);
  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req;
  logic [N_REQ*DELAY_W-1:0] delay;
  logic                     abort;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         pulse;
  logic                     busy;
  logic [OWNER_W-1:0]       owner;

  modport master (
    output req, delay, abort,
    input  gnt, pulse, busy, owner
  );

  modport slave (
    input  req, delay, abort,
    output gnt, pulse, busy, owner
  );
endinterface

// File: rtl/pulse_scheduler.sv
// Shared programmable delay timer. Requesters are granted one at a time in
// round-robin order. The granted requester's delay is counted down, and a
// one-cycle pulse is returned on that requester's own line.
module pulse_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_scheduler_if.slave bus
);
  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The pointer starts on the last index, so requester 0 is first in line after reset.
  localparam logic [OWNER_W-1:0] PTR_RESET = OWNER_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [DELAY_W-1:0] count_reg, count_next;
  logic [OWNER_W-1:0] ptr_reg, ptr_next;
  logic [OWNER_W-1:0] owner_reg, owner_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [N_REQ-1:0]   pulse_reg, pulse_next;
  logic               busy_reg, busy_next;

  // Arbitration helpers
  logic [N_REQ-1:0]   above_ptr;
  logic [N_REQ-1:0]   req_hi;
  logic [N_REQ-1:0]   win_onehot;
  logic [N_REQ-1:0]   owner_onehot;
  logic [DELAY_W-1:0] delay_arr [N_REQ];
  logic [OWNER_W-1:0] hi_idx, lo_idx, win_idx;
  logic               hi_any, win_valid, grant;
  logic [DELAY_W-1:0] win_delay;

  // Per-requester slices. These are the mask of indices strictly above the
  // pointer, the unpacked delay fields, and one-hot decodes of the winner
  // and the owner.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign above_ptr[gi]    = (OWNER_W'(gi) > ptr_reg);
      assign delay_arr[gi]    = bus.delay[gi*DELAY_W +: DELAY_W];
      assign win_onehot[gi]   = (win_idx == OWNER_W'(gi));
      assign owner_onehot[gi] = (owner_reg == OWNER_W'(gi));
    end
  endgenerate

  // Round robin works in two steps. It first picks the lowest requester
  // above the pointer. If there is none, it wraps and picks the lowest
  // requester overall.
  assign req_hi    = bus.req & above_ptr;
  assign hi_any    = |req_hi;
  assign win_valid = |bus.req;

  // Lowest set bit of the upper and the full request vectors
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        hi_idx = OWNER_W'(i);
      end
      if (bus.req[i]) begin
        lo_idx = OWNER_W'(i);
      end
    end
  end

  assign win_idx   = hi_any ? hi_idx : lo_idx;
  assign win_delay = delay_arr[win_idx];

  // Next-state and registered-output decode
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    gnt_next   = '0;
    pulse_next = '0;
    busy_next  = busy_reg;
    grant      = 1'b0;

    case (state_reg)
      IDLE: begin
        // An idle cycle ends any outstanding grant, including a pulse cycle.
        // Abort has no meaning here.
        busy_next = 1'b0;
        grant     = win_valid;
      end
      COUNT: begin
        if (bus.abort) begin
          // Abort takes priority over expiry. The timer is released at once,
          // so a waiting requester can be granted in the very next cycle.
          busy_next  = 1'b0;
          state_next = IDLE;
          grant      = win_valid;
        end else if (count_reg == '0) begin
          pulse_next = owner_onehot;
          busy_next  = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase

    if (grant) begin
      gnt_next   = win_onehot;
      owner_next = win_idx;
      ptr_next   = win_idx;
      count_next = win_delay;
      busy_next  = 1'b1;
      state_next = COUNT;
    end
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      ptr_reg   <= PTR_RESET;
      owner_reg <= '0;
      gnt_reg   <= '0;
      pulse_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      gnt_reg   <= gnt_next;
      pulse_reg <= pulse_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.pulse = pulse_reg;
  assign bus.busy  = busy_reg;
  assign bus.owner = owner_reg;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler. A deadline-based reference model predicts every
// output in every cycle. Directed steps then pin down the documented timing
// points. A randomized phase follows.
module tb_pulse_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_scheduler_if #(.N_REQ(N), .DELAY_W(DW)) bus ();

  pulse_scheduler #(.N_REQ(N), .DELAY_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model. It records who owns the timer and the absolute cycle
  // in which that owner's pulse is due.
  bit         m_act   = 1'b0;
  int         m_due   = 0;
  int         m_owner = 0;
  int         m_last  = N - 1;
  logic [N-1:0] e_gnt   = '0;
  logic [N-1:0] e_pulse = '0;
  logic         e_busy  = 1'b0;
  logic [1:0]   e_owner = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_delay(input int i, input int d);
    bus.delay[i*DW +: DW] = DW'(d);
  endtask

  // Predict the outputs of the next cycle from the inputs currently applied
  function automatic void predict();
    bit free;
    int w;
    int d;
    if (!rst_n) begin
      m_act   = 1'b0;
      m_last  = N - 1;
      m_owner = 0;
      e_gnt   = '0;
      e_pulse = '0;
      e_busy  = 1'b0;
      e_owner = '0;
      return;
    end
    e_gnt   = '0;
    e_pulse = '0;
    e_busy  = 1'b0;
    free    = !m_act;
    if (m_act) begin
      if (bus.abort) begin
        m_act = 1'b0;
        free  = 1'b1;
      end else if (cyc + 1 == m_due) begin
        e_pulse[m_owner] = 1'b1;
        e_busy           = 1'b1;
        m_act            = 1'b0;
      end else begin
        e_busy = 1'b1;
      end
    end
    if (free && (bus.req != '0)) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int i = (m_last + k) % N;
        if (w < 0 && bus.req[i]) w = i;
      end
      d          = int'(bus.delay[w*DW +: DW]);
      e_gnt[w]   = 1'b1;
      e_owner    = 2'(w);
      m_owner    = w;
      m_last     = w;
      m_act      = 1'b1;
      m_due      = cyc + 1 + d + 1;
      e_busy     = 1'b1;
    end
  endfunction

  // One clock cycle: model prediction, edge, then compare all outputs
  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    cyc++;
    chk("model_gnt",   32'(bus.gnt),   32'(e_gnt));
    chk("model_pulse", 32'(bus.pulse), 32'(e_pulse));
    chk("model_busy",  32'(bus.busy),  32'(e_busy));
    chk("model_owner", 32'(bus.owner), 32'(e_owner));
  endtask

  task automatic wait_gnt(input int idx, input int max_cyc, output int g);
    g = -1;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (bus.gnt != '0) begin
        g = cyc;
        break;
      end
    end
    chk("gnt_index", 32'(bus.gnt), 32'(1 << idx));
    $display("grant: requester %0d at cycle %0d (gnt=%b)", idx, g, bus.gnt);
  endtask

  initial begin
    int g;
    bus.req   = '0;
    bus.delay = '0;
    bus.abort = 1'b0;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_gnt",   32'(bus.gnt),   32'd0);
    chk("reset_pulse", 32'(bus.pulse), 32'd0);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_owner", 32'(bus.owner), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request: requester 2, delay 3
    set_delay(2, 3);
    bus.req = 4'b0100;
    wait_gnt(2, 5, g);
    chk("single_owner", 32'(bus.owner), 32'd2);
    chk("single_busy_g", 32'(bus.busy), 32'd1);
    bus.req = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("single_busy", 32'(bus.busy), 32'd1);
      chk("single_pulse", 32'(bus.pulse), (k == 4) ? 32'h4 : 32'h0);
    end
    tick();
    chk("single_busy_end", 32'(bus.busy), 32'd0);
    $display("single: pulse to requester 2 checked at G+4 (G=%0d)", g);

    // Zero delay with the request held
    set_delay(0, 0);
    bus.req = 4'b0001;
    wait_gnt(0, 5, g);
    tick();
    chk("zero_pulse", 32'(bus.pulse), 32'h1);
    tick();
    chk("zero_regrant", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    chk("zero_pulse2", 32'(bus.pulse), 32'h1);
    tick();
    $display("zero: pulse at G+1 and re-grant at G+2 checked (G=%0d)", g);

    // Round robin from reset, all four requesting, delay 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_delay(i, 1);
    bus.req = 4'b1111;
    wait_gnt(0, 5, g);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rr_no_pulse", 32'(bus.pulse), 32'h0);
      tick();
      chk("rr_pulse", 32'(bus.pulse), 32'(1 << ((k - 1) % N)));
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % N)));
      $display("round robin: grant %0d to requester %0d at cycle %0d", k, k % N, cyc);
    end
    bus.req = '0;
    for (int k = 0; k < 4; k++) tick();

    // Abort with nothing pending
    set_delay(1, 10);
    bus.req = 4'b0010;
    wait_gnt(1, 5, g);
    bus.req = '0;
    for (int k = 0; k < 5; k++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_pulse", 32'(bus.pulse), 32'h0);
    end
    $display("abort: idle after abort at G+5 checked (G=%0d)", g);

    // Abort with requester 3 waiting
    set_delay(3, 2);
    bus.req = 4'b0010;
    wait_gnt(1, 5, g);
    bus.req = 4'b1000;
    for (int k = 0; k < 5; k++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.req   = '0;
    chk("abort_regrant", 32'(bus.gnt), 32'h8);
    chk("abort_owner",   32'(bus.owner), 32'd3);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_pulse1", 32'(bus.pulse & 4'b0010), 32'h0);
    end
    $display("abort: requester 3 granted at G+6 checked (G=%0d)", g);

    // Abort arriving in the expiry cycle
    set_delay(0, 2);
    bus.req = 4'b0001;
    wait_gnt(0, 5, g);
    bus.req = '0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("collide_pulse", 32'(bus.pulse), 32'h0);
    chk("collide_busy",  32'(bus.busy),  32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("collide_no_pulse", 32'(bus.pulse), 32'h0);
    end
    $display("collision: abort beats expiry checked (G=%0d)", g);

    // Reset in the middle of a long countdown
    set_delay(2, 255);
    bus.req = 4'b0100;
    wait_gnt(2, 5, g);
    bus.req = '0;
    for (int k = 0; k < 100; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_gnt",   32'(bus.gnt),   32'd0);
    chk("rstmid_pulse", 32'(bus.pulse), 32'd0);
    chk("rstmid_busy",  32'(bus.busy),  32'd0);
    chk("rstmid_owner", 32'(bus.owner), 32'd0);
    for (int k = 0; k < 300; k++) begin
      tick();
      chk("rstmid_no_pulse", 32'(bus.pulse), 32'h0);
    end
    for (int i = 0; i < N; i++) set_delay(i, 1);
    bus.req = 4'b1111;
    wait_gnt(0, 5, g);
    bus.req = '0;
    for (int k = 0; k < 5; k++) tick();
    $display("reset mid-count: lowest index granted afterwards at cycle %0d", g);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      bus.req   = 4'($urandom) & 4'($urandom);
      bus.abort = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) set_delay(i, int'($urandom_range(0, 5)));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n     = 1'b1;
    bus.req   = '0;
    bus.abort = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    $display("random: 4000 cycles of mixed traffic compared against the model");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
